spart: RTL and testbench

SPART -- requirements
Module: spart

---
 rtl/spart_pkg.sv | 14 +
 rtl/spart_if.sv | 13 +
 rtl/spart_baud_gen.sv | 26 ++
 rtl/spart.sv | 196 +++++++++++++++++++
 tb/tb_spart.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// SPART shared constants: register map, reset divisor, oversample ratio and serial FSM states.
package spart_pkg;

    localparam int          DATA_W      = 8;
    localparam logic [1:0]  ADDR_BUF    = 2'b00;
    localparam logic [1:0]  ADDR_STAT   = 2'b01;
    localparam logic [1:0]  ADDR_DIVL   = 2'b10;
    localparam logic [1:0]  ADDR_DIVH   = 2'b11;
    localparam logic [15:0] DIV_RESET   = 16'h0145;
    localparam int          OVERSAMPLE  = 16;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

endpackage

// File: rtl/spart_if.sv
// SPART processor-side control bus (data lines travel separately on the shared databus).
interface spart_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);

endinterface

// File: rtl/spart_baud_gen.sv
// Baud tick generator: one-cycle tick every divisor+1 clocks (16x the bit rate).
module spart_baud_gen
    import spart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic        reload,
    output logic        tick
);

    logic [15:0] cnt;

    // Down-counter; a new divisor is picked up on reload or at the next tick boundary.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 16'd0;
        else if (reload || cnt == 16'd0)
            cnt <= divisor;
        else
            cnt <= cnt - 16'd1;
    end

    assign tick = (cnt == 16'd0);

endmodule

// File: rtl/spart.sv
// SPART: bus-mapped 8N1 UART with programmable baud divisor.
// Define SPART_RX_SYNC_EN to add a two-flop synchronizer on rxd.
module spart
    import spart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    spart_if.slave      bus,
    inout  wire  [7:0]  databus,
    output logic        txd,
    input  logic        rxd
);

    localparam int            TW     = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);

    logic [15:0]       divisor;
    logic              tick;
    logic              wr, rd, wr_buf, rd_buf, wr_divl, wr_divh, rd_en;
    logic [DATA_W-1:0] rd_data, rx_buf;
    logic              rda;

    ser_state_t        tx_state, tx_nxt;
    logic [TW-1:0]     tx_tcnt;
    logic [2:0]        tx_bidx;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_go;

    ser_state_t        rx_state, rx_nxt;
    logic [TW-1:0]     rx_tcnt;
    logic [2:0]        rx_bidx;
    logic [DATA_W-1:0] rx_sh;
    logic              rxd_p0, rxd_p1, rx_fall, frame_ok;

    assign wr      = bus.iocs & ~bus.iorw;
    assign rd      = bus.iocs &  bus.iorw;
    assign wr_buf  = wr && bus.ioaddr == ADDR_BUF;
    assign wr_divl = wr && bus.ioaddr == ADDR_DIVL;
    assign wr_divh = wr && bus.ioaddr == ADDR_DIVH;
    assign rd_buf  = rd && bus.ioaddr == ADDR_BUF;
    assign rd_en   = rd && (bus.ioaddr == ADDR_BUF || bus.ioaddr == ADDR_STAT);

    always_comb begin
        rd_data = rx_buf;
        if (bus.ioaddr == ADDR_STAT)
            rd_data = {6'b0, bus.tbr, rda};
    end

    assign databus = rd_en ? rd_data : 8'hzz;
    assign bus.rda = rda;
    assign bus.tbr = (tx_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            divisor <= DIV_RESET;
        else if (wr_divl)
            divisor[7:0] <= databus;
        else if (wr_divh)
            divisor[15:8] <= databus;
    end

    spart_baud_gen u_baud (
        .clk     (clk),
        .rst     (rst),
        .divisor (wr_divh ? {databus, divisor[7:0]} : divisor),
        .reload  (wr_divh),
        .tick    (tick)
    );

    // ---------------- transmitter ----------------
    assign tx_go = wr_buf && tx_state == IDLE;

    always_comb begin
        tx_nxt = tx_state;
        case (tx_state)
            IDLE:  if (tx_go) tx_nxt = START;
            START: if (tick && tx_tcnt == T_LAST) tx_nxt = DATA;
            DATA:  if (tick && tx_tcnt == T_LAST && tx_bidx == 3'd7) tx_nxt = STOP;
            STOP:  if (tick && tx_tcnt == T_LAST) tx_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_tcnt  <= '0;
            tx_bidx  <= '0;
        end else begin
            tx_state <= tx_nxt;
            if (tx_go) begin
                tx_tcnt <= '0;
                tx_bidx <= '0;
            end else if (tick && tx_state != IDLE) begin
                tx_tcnt <= tx_tcnt + 1'b1;
                if (tx_state == DATA && tx_tcnt == T_LAST)
                    tx_bidx <= tx_bidx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_go)
            tx_sh <= databus;
        else if (tx_state == DATA && tick && tx_tcnt == T_LAST)
            tx_sh <= tx_sh >> 1;
    end

    always_comb begin
        txd = 1'b1;
        if (tx_state == START)
            txd = 1'b0;
        else if (tx_state == DATA)
            txd = tx_sh[0];
    end

    // ---------------- receiver input stage ----------------
`ifdef SPART_RX_SYNC_EN
    logic rxd_s0, rxd_s1;
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s0 <= 1'b1;
            rxd_s1 <= 1'b1;
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_s0 <= rxd;
            rxd_s1 <= rxd_s0;
            rxd_p0 <= rxd_s1;
            rxd_p1 <= rxd_p0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
        end
    end
`endif

    assign rx_fall  = rxd_p1 & ~rxd_p0;
    assign frame_ok = rx_state == STOP && tick && rx_tcnt == T_LAST && rxd_p0;

    // ---------------- receiver ----------------
    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            IDLE:  if (rx_fall) rx_nxt = START;
            START: if (tick && rx_tcnt == T_HALF) rx_nxt = rxd_p0 ? IDLE : DATA;
            DATA:  if (tick && rx_tcnt == T_LAST && rx_bidx == 3'd7) rx_nxt = STOP;
            STOP:  if (tick && rx_tcnt == T_LAST) rx_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_tcnt  <= '0;
            rx_bidx  <= '0;
        end else begin
            rx_state <= rx_nxt;
            if (rx_state == IDLE) begin
                rx_tcnt <= '0;
                rx_bidx <= '0;
            end else if (tick) begin
                // Restart the count at mid start bit so later samples land mid-bit.
                rx_tcnt <= (rx_state == START && rx_tcnt == T_HALF) ? '0 : rx_tcnt + 1'b1;
                if (rx_state == DATA && rx_tcnt == T_LAST)
                    rx_bidx <= rx_bidx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == DATA && tick && rx_tcnt == T_LAST)
            rx_sh <= {rxd_p0, rx_sh[7:1]};
    end

    // A completing frame wins over a coinciding buffer read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_buf <= '0;
            rda    <= 1'b0;
        end else if (frame_ok) begin
            rx_buf <= rx_sh;
            rda    <= 1'b1;
        end else if (rd_buf) begin
            rda    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spart.sv
// Directed self-checking bench for spart: register access, baud timing, TX framing, RX paths.
module tb_spart;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       txd;
    logic       tb_drv;
    logic [7:0] tb_data;
    wire  [7:0] databus;

    int n_checks = 0;
    int n_errors = 0;

    spart_if bus ();

    assign databus = tb_drv ? tb_data : 8'hzz;

    spart dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .databus (databus),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b1;
        bus.ioaddr = 2'b00;
        tb_drv     = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; tb_data = d; tb_drv = 1'b1;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
        @(negedge clk);
        d = databus;
        @(posedge clk); #1;
        bus_idle();
    endtask

    // Drives one 8N1 frame, cpb clocks per bit, then leaves the line idle high.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int cpb);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        logic [9:0] txf;
        int         n;

        rst = 1'b1; rxd = 1'b1; tb_data = 8'h00;
        bus_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_tbr", 16'(bus.tbr), 16'h1);
        check("rst_txd", 16'(txd), 16'h1);
        check("rst_rda", 16'(bus.rda), 16'h0);
        bus_read(ADDR_STAT, d);
        check("rst_status", 16'(d), 16'h02);
        bus_read(ADDR_BUF, d);
        check("rst_rxbuf", 16'(d), 16'h00);

        // Baud period with divisor 0x0145
        bus_write(ADDR_DIVL, 8'h45);
        bus_write(ADDR_DIVH, 8'h01);
        @(negedge clk);
        n = 0;
        while (!dut.u_baud.tick && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dut.u_baud.tick && n < 2000);
        check("baud_period", 16'(n), 16'd326);

        // Transmit 0xA5 at one tick per clock; a second write mid-frame must be dropped
        bus_write(ADDR_DIVL, 8'h00);
        bus_write(ADDR_DIVH, 8'h00);
        bus_write(ADDR_BUF, 8'hA5);
        txf = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 160; i++) begin
            if (i == 20) begin
                bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = ADDR_BUF;
                tb_data = 8'h00; tb_drv = 1'b1;
            end else if (i == 21) begin
                bus_idle();
            end
            @(negedge clk);
            if (i % 16 == 8)
                check($sformatf("tx_bit%0d", i / 16), 16'(txd), 16'(txf[i / 16]));
            if (i % 32 == 4)
                check($sformatf("tx_busy%0d", i), 16'(bus.tbr), 16'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("tx_done_tbr", 16'(bus.tbr), 16'h1);
        check("tx_done_txd", 16'(txd), 16'h1);

        // Reset in the middle of a frame
        bus_write(ADDR_BUF, 8'h00);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("midtx_txd", 16'(txd), 16'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midtx_rst_txd", 16'(txd), 16'h1);
        check("midtx_rst_tbr", 16'(bus.tbr), 16'h1);

        // Receive 0x3C
        bus_write(ADDR_DIVL, 8'h00);
        bus_write(ADDR_DIVH, 8'h00);
        send_frame(8'h3C, 1'b1, 16);
        check("rx_rda", 16'(bus.rda), 16'h1);
        bus_read(ADDR_BUF, d);
        check("rx_data", 16'(d), 16'h3C);
        @(negedge clk);
        check("rx_rda_clr", 16'(bus.rda), 16'h0);

        // Overrun keeps the newest byte, then a framing error changes nothing
        send_frame(8'h11, 1'b1, 16);
        send_frame(8'h22, 1'b1, 16);
        bus_read(ADDR_STAT, d);
        check("ovr_status", 16'(d), 16'h03);
        bus_read(ADDR_BUF, d);
        check("ovr_data", 16'(d), 16'h22);
        send_frame(8'h5A, 1'b0, 16);
        check("ferr_rda", 16'(bus.rda), 16'h0);
        bus_read(ADDR_BUF, d);
        check("ferr_data", 16'(d), 16'h22);

        // Short glitch at one tick per clock: start seen, then rejected at mid-bit
        rxd = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("glitch_start", 16'(dut.rx_state), 16'(START));
        @(posedge clk); #1 rxd = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("glitch_idle", 16'(dut.rx_state), 16'(IDLE));
        check("glitch_rda", 16'(bus.rda), 16'h0);

        // 12-clock glitch with two clocks per tick (mid start bit 16 clocks in)
        bus_write(ADDR_DIVL, 8'h01);
        bus_write(ADDR_DIVH, 8'h00);
        rxd = 1'b0;
        repeat (12) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("glitch12_idle", 16'(dut.rx_state), 16'(IDLE));
        check("glitch12_rda", 16'(bus.rda), 16'h0);
        @(posedge clk); #1;
        send_frame(8'h96, 1'b1, 32);
        check("rx_div1_rda", 16'(bus.rda), 16'h1);
        bus_read(ADDR_BUF, d);
        check("rx_div1_data", 16'(d), 16'h96);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
